// File: rtl/serial_mavg_fir_mc.sv
// Serial-in/serial-out multi-channel moving-average FIR.
// Input words arrive MSB first and rotate through the channels. Each channel
// keeps its own TAPS-deep history and running sum. Results go through a small
// FIFO and are then shifted out MSB first. The output side has backpressure.

// One channel: circular history plus running sum, updated once per word.
module serial_mavg_fir_mc_lane #(
  parameter int DW        = 24,
  parameter int LOG2_TAPS = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          upd,
  input  logic [DW-1:0] x,
  output logic [DW-1:0] avg
);
  localparam int TAPS = 1 << LOG2_TAPS;
  localparam int SW   = DW + LOG2_TAPS;

  logic [TAPS-1:0][DW-1:0] hist;
  logic [LOG2_TAPS-1:0]    ptr;
  logic signed [SW-1:0]    sum, sum_new, x_ext, old_ext;

  // Running-sum update: add the new sample, retire the oldest one.
  always_comb begin
    x_ext   = {{LOG2_TAPS{x[DW-1]}}, x};
    old_ext = {{LOG2_TAPS{hist[ptr][DW-1]}}, hist[ptr]};
    sum_new = sum + x_ext - old_ext;
  end

  // The top DW bits of the sum are the floor of sum/TAPS, which is an
  // arithmetic shift followed by truncation.
  assign avg = sum_new[SW-1 -: DW];

  // History, pointer and sum advance only when this channel's word lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
      ptr  <= '0;
      sum  <= '0;
    end else if (upd) begin
      hist[ptr] <= x;
      ptr       <= ptr + 1'b1;
      sum       <= sum_new;
    end
  end
endmodule

module serial_mavg_fir_mc #(
  parameter  int DATA_WIDTH = 24,
  parameter  int TAPS       = 16,
  parameter  int NUM_CH     = 2,
  parameter  int FIFO_DEPTH = 4,
  localparam int LOG2_TAPS  = $clog2(TAPS),
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_en,
  input  logic            i_bypass,
  input  logic            i_din,
  input  logic            i_din_valid,
  input  logic            i_dout_ready,
  output logic            o_dout,
  output logic            o_dout_valid,
  output logic            o_frame_start,
  output logic [CH_W-1:0] o_ch,
  output logic            o_overflow
);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam int FA = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [BW-1:0]   LAST_BIT  = BW'(DATA_WIDTH - 1);
  localparam logic [CH_W-1:0] LAST_CH   = CH_W'(NUM_CH - 1);
  localparam logic [FA-1:0]   LAST_SLOT = FA'(FIFO_DEPTH - 1);
  localparam logic [FA:0]     FULL_CNT  = (FA + 1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] y;
    logic [CH_W-1:0]       ch;
  } res_t;

  typedef enum logic {IDLE, SHIFT} state_t;

  // ---------------- deserializer ----------------
  logic [DATA_WIDTH-2:0] din_sh;
  logic [DATA_WIDTH-1:0] din_next;
  logic [BW-1:0]         in_cnt;
  logic [CH_W-1:0]       c_in;
  logic [DATA_WIDTH-1:0] x_word;
  logic [CH_W-1:0]       c_word;
  logic                  word_vld;

  assign din_next = {din_sh, i_din};

  // Collect bits. A completed word is held for one enabled edge, which is
  // the edge that updates the filter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      din_sh   <= '0;
      in_cnt   <= '0;
      c_in     <= '0;
      x_word   <= '0;
      c_word   <= '0;
      word_vld <= 1'b0;
    end else if (i_en) begin
      word_vld <= 1'b0;
      if (i_din_valid) begin
        din_sh <= din_next[DATA_WIDTH-2:0];
        if (in_cnt == LAST_BIT) begin
          in_cnt   <= '0;
          x_word   <= din_next;
          c_word   <= c_in;
          c_in     <= (c_in == LAST_CH) ? '0 : c_in + 1'b1;
          word_vld <= 1'b1;
        end else begin
          in_cnt <= in_cnt + 1'b1;
        end
      end
    end
  end

  // ---------------- per-channel filters ----------------
  logic                                push_req;
  logic [NUM_CH-1:0]                   lane_upd;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0]   lane_avg;
  logic [DATA_WIDTH-1:0]               y_res;

  assign push_req = i_en && word_vld;

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_lane
      assign lane_upd[g] = push_req && (c_word == CH_W'(g));
      serial_mavg_fir_mc_lane #(
        .DW        (DATA_WIDTH),
        .LOG2_TAPS (LOG2_TAPS)
      ) u_lane (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .upd   (lane_upd[g]),
        .x     (x_word),
        .avg   (lane_avg[g])
      );
    end
  endgenerate

  // Bypass is looked at on the update edge only. The history is always fed.
  assign y_res = i_bypass ? x_word : lane_avg[c_word];

  // ---------------- result FIFO ----------------
  res_t [FIFO_DEPTH-1:0] fifo_mem;
  logic [FA-1:0]         wr_ptr, rd_ptr;
  logic [FA:0]           fifo_cnt;
  logic                  fifo_full, fifo_empty;
  logic                  push_ok, load, xfer;
  res_t                  rd_data;

  assign fifo_full  = (fifo_cnt == FULL_CNT);
  assign fifo_empty = (fifo_cnt == '0);
  assign rd_data    = fifo_mem[rd_ptr];
  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign push_ok    = push_req && (!fifo_full || load);

  // FIFO storage and pointers. Any dropped result sets the sticky flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fifo_mem   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        fifo_mem[wr_ptr] <= '{y: y_res, ch: c_word};
        wr_ptr           <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
      end
      if (load)
        rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + 1'b1;
      case ({push_ok, load})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (push_req && fifo_full && !load)
        o_overflow <= 1'b1;
    end
  end

  // ---------------- serializer ----------------
  state_t                state, state_nx;
  logic [DATA_WIDTH-1:0] shreg;
  logic [BW-1:0]         bcnt;
  logic [CH_W-1:0]       ch_r;

  // Next state: load from the FIFO when idle, or right after the last bit
  // of a word so that consecutive words go out with no gap.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    xfer     = 1'b0;
    case (state)
      IDLE: begin
        if (i_en && !fifo_empty) begin
          load     = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (i_en && i_dout_ready) begin
          xfer = 1'b1;
          if (bcnt == LAST_BIT) begin
            if (!fifo_empty) load = 1'b1;
            else             state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register and output shifter. Data only moves on an accepted bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      shreg <= '0;
      bcnt  <= '0;
      ch_r  <= '0;
    end else begin
      state <= state_nx;
      if (load) begin
        shreg <= rd_data.y;
        ch_r  <= rd_data.ch;
        bcnt  <= '0;
      end else if (xfer) begin
        shreg <= {shreg[DATA_WIDTH-2:0], 1'b0};
        bcnt  <= (bcnt == LAST_BIT) ? '0 : bcnt + 1'b1;
      end
    end
  end

  assign o_dout        = shreg[DATA_WIDTH-1];
  assign o_dout_valid  = i_en && (state == SHIFT);
  assign o_frame_start = (state == SHIFT) && (bcnt == '0);
  assign o_ch          = ch_r;
endmodule

// File: tb/tb_serial_mavg_fir_mc.sv
// Bench for serial_mavg_fir_mc. A queue-based model computes each expected
// word, and a monitor checks every serialised word against that model. The
// directed sequences also pin exact hand-computed values.
module tb_serial_mavg_fir_mc;
  localparam int DW = 8, TAPS = 4, NUM_CH = 2, FD = 4;

  logic       clk, rst_n, en, bypass, din, din_valid, dout_ready;
  logic       dout, dout_valid, frame_start, overflow;
  logic [0:0] och;

  serial_mavg_fir_mc #(
    .DATA_WIDTH (DW),
    .TAPS       (TAPS),
    .NUM_CH     (NUM_CH),
    .FIFO_DEPTH (FD)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_en          (en),
    .i_bypass      (bypass),
    .i_din         (din),
    .i_din_valid   (din_valid),
    .i_dout_ready  (dout_ready),
    .o_dout        (dout),
    .o_dout_valid  (dout_valid),
    .o_frame_start (frame_start),
    .o_ch          (och),
    .o_overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int rdy_mode = 1;            // 0: ready low, 1: ready high, 2: random
  int hist [NUM_CH][$];
  int m_cin;
  int exp_y[$], exp_c[$], got_w[$], got_c[$];
  int words_out = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: the window is the last TAPS samples of the channel, and the
  // output is the floor of their mean.
  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) hist[c].delete();
    m_cin = 0;
    exp_y.delete();
    exp_c.delete();
  endtask

  task automatic model_push(input logic [7:0] x, input bit byp, input bit drop);
    int s, y;
    hist[m_cin].push_back(int'($signed(x)));
    if (hist[m_cin].size() > TAPS) void'(hist[m_cin].pop_front());
    s = 0;
    foreach (hist[m_cin][k]) s += hist[m_cin][k];
    if (byp) y = int'(x);
    else     y = ((s >= 0) ? s / TAPS : -((-s + TAPS - 1) / TAPS)) & 255;
    if (!drop) begin
      exp_y.push_back(y);
      exp_c.push_back(m_cin);
    end
    m_cin = (m_cin + 1) % NUM_CH;
  endtask

  // Sink-ready driver
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       dout_ready = 1'b0;
      1:       dout_ready = 1'b1;
      default: dout_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: rebuild each output word and compare it with the model queue.
  int mb = 0, cur_ch = 0;
  logic [7:0] acc;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) mb = 0;
      else begin
        if (!en) chk("valid gated by en", int'(dout_valid), 0);
        if (dout_valid && dout_ready) begin
          if (mb == 0) begin
            chk("frame_start on MSB", int'(frame_start), 1);
            cur_ch = int'(och);
          end else begin
            chk("frame_start mid-word", int'(frame_start), 0);
            chk("o_ch stable", int'(och), cur_ch);
          end
          acc = {acc[6:0], dout};
          mb++;
          if (mb == DW) begin
            mb = 0;
            words_out++;
            got_w.push_back(int'(acc));
            got_c.push_back(cur_ch);
            if (exp_y.size() == 0) begin
              n_chk++;
              n_fail++;
              $display("FAIL unexpected word: got %02h ch %0d, none expected", acc, cur_ch);
            end else begin
              chk("word", int'(acc), exp_y[0]);
              chk("word ch", cur_ch, exp_c[0]);
              void'(exp_y.pop_front());
              void'(exp_c.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; din_valid = 1'b0; din = 1'b0; bypass = 1'b0;
    model_reset();
    got_w.delete();
    got_c.delete();
    tick();
    tick();
    chk("reset outputs", int'({dout, dout_valid, frame_start, och, overflow}), 0);
    rst_n = 1'b1;
    en = 1'b1;
    tick();
  endtask

  // Send one word MSB first. rnd inserts idle and enable-low cycles.
  // The trailing enabled cycle is the filter update edge.
  task automatic send_word(input logic [7:0] x, input bit byp, input bit rnd, input bit drop);
    bypass = byp;
    for (int i = 7; i >= 0; i--) begin
      if (rnd) begin
        while ($urandom_range(0, 3) == 0) begin
          en        = ($urandom_range(0, 1) == 0);
          din_valid = en ? 1'b0 : 1'($urandom_range(0, 1));
          din       = 1'($urandom_range(0, 1));
          tick();
        end
      end
      en = 1'b1; din_valid = 1'b1; din = x[i];
      tick();
    end
    model_push(x, byp, drop);
    en = 1'b1; din_valid = 1'b0;
    tick();
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((exp_y.size() != 0 || dout_valid) && k < 3000) begin
      tick();
      k++;
    end
    if (k >= 3000) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain timeout: %0d words still expected", exp_y.size());
    end
  endtask

  task automatic chk_seq(input string nm, input int ch, input int e[6], input int n);
    int idx = 0;
    foreach (got_w[k]) begin
      if (got_c[k] == ch) begin
        if (idx < n) chk($sformatf("%s[%0d]", nm, idx), got_w[k], e[idx]);
        idx++;
      end
    end
    chk({nm, " count"}, idx, n);
  endtask

  initial begin
    int e[6];
    int v;
    int wo0;
    int k;
    rst_n = 1'b0; en = 1'b0; bypass = 1'b0; din = 1'b0; din_valid = 1'b0; dout_ready = 1'b1;

    // Ramp with 2-cycle latency; ch1 carries zeros.
    do_reset();
    send_word(8'h40, 0, 0, 0);
    chk("latency E+1 valid", int'(dout_valid), 0);
    tick();
    chk("latency E+2 valid", int'(dout_valid), 1);
    chk("latency E+2 frame_start", int'(frame_start), 1);
    send_word(8'h00, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      send_word(8'h40, 0, 0, 0);
      send_word(8'h00, 0, 0, 0);
    end
    wait_drain();
    e = '{'h10, 'h20, 'h30, 'h40, 'h40, 0};
    chk_seq("ramp ch0", 0, e, 5);
    e = '{0, 0, 0, 0, 0, 0};
    chk_seq("ramp ch1", 1, e, 5);

    // Floor rounding of negative averages.
    do_reset();
    send_word(8'hFF, 0, 0, 0);
    send_word(8'h00, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      send_word(8'h00, 0, 0, 0);
      send_word(8'h00, 0, 0, 0);
    end
    wait_drain();
    e = '{'hFF, 'hFF, 'hFF, 'hFF, 'h00, 0};
    chk_seq("floor ch0", 0, e, 5);

    // Interleaved channels.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_word(8'h40, 0, 0, 0);
      send_word(8'h80, 0, 0, 0);
    end
    wait_drain();
    e = '{'h10, 'h20, 'h30, 'h40, 0, 0};
    chk_seq("ilv ch0", 0, e, 4);
    e = '{'hE0, 'hC0, 'hA0, 'h80, 0, 0};
    chk_seq("ilv ch1", 1, e, 4);
    foreach (got_c[i]) chk("ilv o_ch order", got_c[i], i % 2);

    // Bypass keeps history updating.
    do_reset();
    send_word(8'h11, 1, 0, 0); send_word(8'h00, 1, 0, 0);
    send_word(8'h22, 1, 0, 0); send_word(8'h00, 1, 0, 0);
    send_word(8'h33, 0, 0, 0); send_word(8'h00, 0, 0, 0);
    send_word(8'h44, 0, 0, 0); send_word(8'h00, 0, 0, 0);
    wait_drain();
    e = '{'h11, 'h22, 'h19, 'h2A, 0, 0};
    chk_seq("bypass ch0", 0, e, 4);

    // Backpressure: 1 in serializer, 4 queued, 6th dropped.
    do_reset();
    rdy_mode = 0; dout_ready = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      v = $urandom_range(0, 255);
      send_word(8'(v), 0, 0, i == 5);
    end
    tick();
    chk("overflow set", int'(overflow), 1);
    chk("nothing out while stalled", got_w.size(), 0);
    rdy_mode = 1; dout_ready = 1'b1;
    wo0 = words_out;
    repeat (40) tick();
    chk("5 words back-to-back", words_out - wo0, 5);
    chk("idle after drain", int'(dout_valid), 0);
    chk("overflow sticky", int'(overflow), 1);

    // Reset in the middle of a word.
    en = 1'b1; din_valid = 1'b1;
    din = 1'b1; tick();
    din = 1'b0; tick();
    din = 1'b1; tick();
    rst_n = 1'b0;
    #1;
    chk("async reset outputs", int'({dout, dout_valid, frame_start, och, overflow}), 0);
    din_valid = 1'b0;
    do_reset();
    send_word(8'h7C, 0, 0, 0);
    send_word(8'h84, 0, 0, 0);
    wait_drain();
    e = '{'h1F, 0, 0, 0, 0, 0};
    chk_seq("post-reset ch0", 0, e, 1);
    e = '{'hE1, 0, 0, 0, 0, 0};
    chk_seq("post-reset ch1", 1, e, 1);

    // Random traffic, throttled so the FIFO cannot overflow.
    rdy_mode = 2;
    for (int n = 0; n < 200; n++) begin
      k = 0;
      while (exp_y.size() >= 3 && k < 2000) begin
        tick();
        k++;
      end
      if (k >= 2000) begin
        n_chk++;
        n_fail++;
        $display("FAIL throttle timeout: %0d words pending", exp_y.size());
      end
      send_word(8'($urandom_range(0, 255)), $urandom_range(0, 3) == 0, 1, 0);
    end
    wait_drain();
    chk("no overflow in random phase", int'(overflow), 0);
    chk("model queue empty", exp_y.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog timeout after %0d checks", n_chk);
    $fatal(1, "watchdog");
  end
endmodule
